// File: rtl/AMITypes.sv
// Shared AMI memory-port request type plus the tuning constants for the DNN2AMI
// request mux.
package AMITypes;

    typedef struct packed {
        logic         valid;
        logic         isWrite;
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  size;
    } AMIRequest;

    localparam int DNN2AMI_MUX_MAX_RD_OUT = 16;
    localparam int DNN2AMI_MUX_WR_WEIGHT  = 4;

endpackage

// File: rtl/ami_req_q2.sv
// Two-entry register FIFO of AMIRequest. The head is always visible, and the
// count is registered so that callers can derive "space" without seeing the pop.
module ami_req_q2
    import AMITypes::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  AMIRequest push_req,
    input  logic      pop,
    output AMIRequest head,
    output logic [1:0] count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       pop_ok;
    logic       push_ok;

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign pop_ok  = pop && (count_reg != 2'd0);
    assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_entry
            AMIRequest entry_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_req;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = rd_ptr_reg ? gen_entry[1].entry_reg : gen_entry[0].entry_reg;
    assign count = count_reg;

endmodule

// File: rtl/dnn2ami_req_mux.sv
// Merges the DNN2AMI read and write request streams onto one AMI port using a
// weighted round-robin with read-credit throttling and a 2-entry output queue.
module dnn2ami_req_mux
    import AMITypes::*;
#(
    parameter int MAX_RD_OUTSTANDING = DNN2AMI_MUX_MAX_RD_OUT,
    parameter int WR_WEIGHT          = DNN2AMI_MUX_WR_WEIGHT,
    parameter int CNT_W              = $clog2(MAX_RD_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_reqValid,
    input  AMIRequest        rd_req,
    output logic             rd_grant,
    input  logic             wr_reqValid,
    input  AMIRequest        wr_req,
    output logic             wr_grant,
    input  logic             rd_resp_accept,
    output logic             reqValid,
    output AMIRequest        reqOut,
    input  logic             reqOut_grant,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic             err_credit_underflow
);

    localparam int RUN_W = $clog2(WR_WEIGHT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RD_OUTSTANDING);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WR_WEIGHT);
    localparam logic [0:0] LAST_RD = 1'b0;
    localparam logic [0:0] LAST_WR = 1'b1;

    logic [1:0]       q_count;
    logic             space;
    logic             rd_elig;
    logic             wr_elig;
    logic             grant_rd;
    logic             grant_wr;
    logic             pop;
    AMIRequest        push_req;
    logic [0:0]       last_reg;
    logic [RUN_W-1:0] wr_run_reg;
    logic [CNT_W-1:0] rd_cnt_reg;
    logic             err_reg;

    // Eligibility uses only registered state, so reqOut_grant never reaches the grants.
    assign space   = (q_count < 2'd2);
    assign rd_elig = rd_reqValid && space && (rd_cnt_reg < MAX_CNT);
    assign wr_elig = wr_reqValid && space;

    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (!rst) begin
            if (rd_elig && wr_elig) begin
                if ((last_reg == LAST_RD) || (wr_run_reg < RUN_MAX)) begin
                    grant_wr = 1'b1;
                end else begin
                    grant_rd = 1'b1;
                end
            end else begin
                grant_rd = rd_elig;
                grant_wr = wr_elig;
            end
        end
    end

    always_comb begin
        push_req       = grant_wr ? wr_req : rd_req;
        push_req.valid = 1'b1;
    end

    assign pop = reqValid && reqOut_grant;

    ami_req_q2 u_q (
        .clk      (clk),
        .rst      (rst),
        .push     (grant_rd || grant_wr),
        .push_req (push_req),
        .pop      (pop),
        .head     (reqOut),
        .count    (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg   <= LAST_RD;
            wr_run_reg <= '0;
        end else if (grant_wr) begin
            last_reg <= LAST_WR;
            if (wr_run_reg != RUN_MAX) begin
                wr_run_reg <= wr_run_reg + 1'b1;
            end
        end else if (grant_rd) begin
            last_reg   <= LAST_RD;
            wr_run_reg <= '0;
        end
    end

    // A response arriving with no reads outstanding is dropped and flagged until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            case ({grant_rd, rd_resp_accept})
                2'b10: rd_cnt_reg <= rd_cnt_reg + 1'b1;
                2'b01: begin
                    if (rd_cnt_reg == '0) begin
                        err_reg <= 1'b1;
                    end else begin
                        rd_cnt_reg <= rd_cnt_reg - 1'b1;
                    end
                end
                default: rd_cnt_reg <= rd_cnt_reg;
            endcase
        end
    end

    assign rd_grant             = grant_rd;
    assign wr_grant             = grant_wr;
    assign reqValid             = (q_count != 2'd0);
    assign rd_outstanding       = rd_cnt_reg;
    assign err_credit_underflow = err_reg;

endmodule

// File: tb/tb_dnn2ami_req_mux.sv
// Directed bench for dnn2ami_req_mux: arbitration order, credit throttling,
// queue back-pressure, credit corner cases and mid-operation reset.
module tb_dnn2ami_req_mux;
    import AMITypes::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_reqValid;
    AMIRequest  rd_req;
    logic       rd_grant;
    logic       wr_reqValid;
    AMIRequest  wr_req;
    logic       wr_grant;
    logic       rd_resp_accept;
    logic       reqValid;
    AMIRequest  reqOut;
    logic       reqOut_grant;
    logic [4:0] rd_outstanding;
    logic       err_credit_underflow;

    int n_checks = 0;
    int n_pass   = 0;
    int rd_idx   = 0;
    int wr_idx   = 0;

    bit exp_w [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    always #5 clk = ~clk;

    dnn2ami_req_mux dut (
        .clk                  (clk),
        .rst                  (rst),
        .rd_reqValid          (rd_reqValid),
        .rd_req               (rd_req),
        .rd_grant             (rd_grant),
        .wr_reqValid          (wr_reqValid),
        .wr_req               (wr_req),
        .wr_grant             (wr_grant),
        .rd_resp_accept       (rd_resp_accept),
        .reqValid             (reqValid),
        .reqOut               (reqOut),
        .reqOut_grant         (reqOut_grant),
        .rd_outstanding       (rd_outstanding),
        .err_credit_underflow (err_credit_underflow)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    function automatic AMIRequest mk_req(input logic is_wr, input logic [63:0] addr);
        AMIRequest r;
        r         = '0;
        r.isWrite = is_wr;
        r.addr    = addr;
        r.data    = {8{addr}};
        r.size    = is_wr ? 64'd8 : 64'd64;
        return r;
    endfunction

    task automatic drive_reqs();
        rd_req = mk_req(1'b0, 64'h1000 + 64'(rd_idx));
        wr_req = mk_req(1'b1, 64'h2000 + 64'(wr_idx));
    endtask

    // Upstream model: advance to the next request on the side that was granted.
    task automatic step();
        logic g_r;
        logic g_w;
        g_r = rd_grant;
        g_w = wr_grant;
        @(posedge clk);
        #1;
        if (g_r) rd_idx++;
        if (g_w) wr_idx++;
        drive_reqs();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        rd_reqValid    = 1'b0;
        wr_reqValid    = 1'b0;
        rd_resp_accept = 1'b0;
        reqOut_grant   = 1'b0;
        rd_idx         = 0;
        wr_idx         = 0;
        drive_reqs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] prev_addr;
        int          exp_rd_n;
        int          exp_wr_n;
        int          g;

        // Reset state, with both inputs requesting during reset
        rst            = 1'b1;
        rd_reqValid    = 1'b1;
        wr_reqValid    = 1'b1;
        rd_resp_accept = 1'b0;
        reqOut_grant   = 1'b1;
        drive_reqs();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_rd_grant", 64'(rd_grant), 64'd0);
        check_val("rst_wr_grant", 64'(wr_grant), 64'd0);
        check_val("rst_reqValid", 64'(reqValid), 64'd0);
        check_val("rst_rd_out", 64'(rd_outstanding), 64'd0);
        check_val("rst_err", 64'(err_credit_underflow), 64'd0);

        // 1: writes only, one-cycle latency, passthrough
        do_reset();
        reqOut_grant = 1'b1;
        for (int c = 0; c < 5; c++) begin
            wr_reqValid = (wr_idx < 3);
            #2;
            check_val("t1_wr_grant", 64'(wr_grant), 64'(c < 3));
            check_val("t1_rd_grant", 64'(rd_grant), 64'd0);
            check_val("t1_reqValid", 64'(reqValid), 64'(c >= 1 && c <= 3));
            if (c >= 1 && c <= 3) begin
                check_val("t1_addr", reqOut.addr, 64'h2000 + 64'(c - 1));
                check_val("t1_data", reqOut.data[63:0], 64'h2000 + 64'(c - 1));
                check_val("t1_size", reqOut.size, 64'd8);
                check_val("t1_valid", 64'(reqOut.valid), 64'd1);
            end
            step();
        end

        // 2: both valid, weighted round-robin W,W,W,W,R,...
        do_reset();
        reqOut_grant = 1'b1;
        rd_reqValid  = 1'b1;
        wr_reqValid  = 1'b1;
        exp_rd_n     = 0;
        exp_wr_n     = 0;
        prev_addr    = '0;
        for (int c = 0; c < 10; c++) begin
            #2;
            check_val("t2_wr_grant", 64'(wr_grant), 64'(exp_w[c]));
            check_val("t2_rd_grant", 64'(rd_grant), 64'(!exp_w[c]));
            if (c > 0) check_val("t2_addr", reqOut.addr, prev_addr);
            if (exp_w[c]) begin
                prev_addr = 64'h2000 + 64'(exp_wr_n);
                exp_wr_n++;
            end else begin
                prev_addr = 64'h1000 + 64'(exp_rd_n);
                exp_rd_n++;
            end
            step();
        end

        // 3: credit limit, one credit returned, writes still flow
        do_reset();
        reqOut_grant = 1'b1;
        rd_reqValid  = 1'b1;
        g            = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (rd_grant) g++;
            if (c == 15) check_val("t3_grant15", 64'(rd_grant), 64'd1);
            if (c == 16) check_val("t3_grant16", 64'(rd_grant), 64'd0);
            step();
        end
        check_val("t3_total", 64'(g), 64'd16);
        check_val("t3_rd_out", 64'(rd_outstanding), 64'd16);
        rd_resp_accept = 1'b1;
        #2;
        check_val("t3_acc_grant", 64'(rd_grant), 64'd0);
        step();
        rd_resp_accept = 1'b0;
        #2;
        check_val("t3_extra_grant", 64'(rd_grant), 64'd1);
        step();
        check_val("t3_rd_out_again", 64'(rd_outstanding), 64'd16);
        wr_reqValid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #2;
            check_val("t3_wr_flow", 64'(wr_grant), 64'd1);
            check_val("t3_rd_blocked", 64'(rd_grant), 64'd0);
            step();
        end

        // 4: output stalled, queue fills, FIFO order on release
        do_reset();
        reqOut_grant = 1'b0;
        rd_reqValid  = 1'b1;
        #2;
        check_val("t4_rd_grant0", 64'(rd_grant), 64'd1);
        check_val("t4_wr_grant0", 64'(wr_grant), 64'd0);
        step();
        wr_reqValid = 1'b1;
        #2;
        check_val("t4_wr_grant1", 64'(wr_grant), 64'd1);
        check_val("t4_rd_grant1", 64'(rd_grant), 64'd0);
        check_val("t4_head1", reqOut.addr, 64'h1000);
        step();
        for (int c = 0; c < 2; c++) begin
            #2;
            check_val("t4_full_rd", 64'(rd_grant), 64'd0);
            check_val("t4_full_wr", 64'(wr_grant), 64'd0);
            check_val("t4_full_valid", 64'(reqValid), 64'd1);
            step();
        end
        reqOut_grant = 1'b1;
        rd_reqValid  = 1'b0;
        wr_reqValid  = 1'b0;
        #2;
        check_val("t4_out0_addr", reqOut.addr, 64'h1000);
        check_val("t4_out0_wr", 64'(reqOut.isWrite), 64'd0);
        step();
        #2;
        check_val("t4_out1_addr", reqOut.addr, 64'h2000);
        check_val("t4_out1_wr", 64'(reqOut.isWrite), 64'd1);
        step();
        #2;
        check_val("t4_empty", 64'(reqValid), 64'd0);

        // 5: simultaneous inc/dec, underflow at zero
        do_reset();
        reqOut_grant = 1'b1;
        rd_reqValid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            step();
        end
        check_val("t5_rd_out5", 64'(rd_outstanding), 64'd5);
        rd_resp_accept = 1'b1;
        #2;
        check_val("t5_same_grant", 64'(rd_grant), 64'd1);
        step();
        check_val("t5_rd_out_hold", 64'(rd_outstanding), 64'd5);
        rd_reqValid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            step();
        end
        check_val("t5_rd_out0", 64'(rd_outstanding), 64'd0);
        check_val("t5_err_clear", 64'(err_credit_underflow), 64'd0);
        #2;
        step();
        check_val("t5_rd_out_floor", 64'(rd_outstanding), 64'd0);
        check_val("t5_err_set", 64'(err_credit_underflow), 64'd1);
        rd_resp_accept = 1'b0;
        #2;
        step();
        check_val("t5_err_sticky", 64'(err_credit_underflow), 64'd1);

        // 6: reset mid-operation with two queued and seven outstanding
        do_reset();
        reqOut_grant   = 1'b1;
        rd_resp_accept = 1'b1;
        #2;
        step();
        rd_resp_accept = 1'b0;
        check_val("t6_err_pre", 64'(err_credit_underflow), 64'd1);
        rd_reqValid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #2;
            step();
        end
        rd_reqValid  = 1'b0;
        reqOut_grant = 1'b0;
        wr_reqValid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            step();
        end
        #2;
        check_val("t6_full_wr", 64'(wr_grant), 64'd0);
        check_val("t6_rd_out7", 64'(rd_outstanding), 64'd7);
        check_val("t6_valid_pre", 64'(reqValid), 64'd1);
        rst         = 1'b1;
        rd_reqValid = 1'b1;
        #2;
        check_val("t6_rst_rd_grant", 64'(rd_grant), 64'd0);
        check_val("t6_rst_wr_grant", 64'(wr_grant), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("t6_valid_post", 64'(reqValid), 64'd0);
        check_val("t6_rd_out_post", 64'(rd_outstanding), 64'd0);
        check_val("t6_err_post", 64'(err_credit_underflow), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
